// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low a..g codes (bit0=a, bit6=g), dp kept separate.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low a..g segment code.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed hex display driver with frame-aligned word updates, LZ blanking and dp.
// Latency: o_sel/o_seg registered, 1 cycle after index/visible-word/blank_lz/dp_mask state.
// Backpressure: data_ready low while a word is pending; it reopens when the pending word goes visible.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic        data_ready,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done
);

    localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      vis_word;
    logic [31:0]      pend_word;
    logic             pend_vld;

    logic             tick;
    logic             boundary;
    logic             accept;
    logic             load_vis;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_code;
    logic [2:0]       top_digit;
    logic             blanked;
    logic [6:0]       seg_body;

    assign tick       = (cnt == CNT_MAX);
    assign boundary   = tick && (idx == 3'(NUM_DIGITS - 1));
    assign data_ready = ~pend_vld;
    assign accept     = data_valid && data_ready;
    assign load_vis   = boundary && pend_vld;
    assign cur_nibble = vis_word[{idx, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_code)
    );

    // Highest non-zero digit; digit 0 is the floor so a zero word still shows one "0".
    always_comb begin
        top_digit = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (vis_word[4*i +: 4] != 4'h0) begin
                top_digit = 3'(i);
            end
        end
    end

    assign blanked  = blank_lz && (idx > top_digit);
    assign seg_body = blanked ? SEG_BLANK : cur_code;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            vis_word   <= 32'h0;
            pend_word  <= 32'h0;
            pend_vld   <= 1'b0;
            frame_done <= 1'b0;
            o_sel      <= 8'hFF;
            o_seg      <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end

            // Transfer uses pre-edge pending contents; accept only happens when pending is empty.
            if (load_vis) begin
                vis_word <= pend_word;
            end
            if (accept) begin
                pend_word <= data_in;
                pend_vld  <= 1'b1;
            end else if (load_vis) begin
                pend_vld  <= 1'b0;
            end
            frame_done <= load_vis;

            o_sel <= ~(8'b1 << idx);
            o_seg <= {~dp_mask[idx], seg_body};
        end
    end

endmodule
